// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Purpose : Core-to-bus load/store adapter with lane steering, load extension,
//           bus timeout, and optional misalignment trap (MISALIGN_TRAP_EN).
// Rev     : 1.0
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [1:0]  adr_lo;
    logic [2:0]  f3;
    logic        we;
    logic        start, trap, timeout_hit, misaligned;
    logic [3:0]  new_be;
    logic [31:0] new_wdata, load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (Funct3[1:0] == 2'b01 && DataAdr[0]) ||
                        (Funct3[1] && DataAdr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        trap        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: if (MemRead || MemWrite) begin
                start = 1'b1;
                if (misaligned) begin
                    trap       = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = REQ;
                end
            end
            REQ: if (bus_ack) begin
                state_next = DONE;
            end else if (cnt == CNT_LAST) begin
                timeout_hit = 1'b1;
                state_next  = DONE;
            end
            default: state_next = IDLE;
        endcase
        // Gated by rst so a request held across reset never shows as a stall
        Stall   = !rst && ((state == IDLE && (MemRead || MemWrite)) || state == REQ);
        bus_req = (state == REQ);
    end

    always_comb begin
        new_be    = 4'b1111;
        new_wdata = 32'h0;
        if (MemWrite) begin
            case (Funct3[1:0])
                2'b00: begin
                    new_be    = 4'b0001 << DataAdr[1:0];
                    new_wdata = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    new_be    = DataAdr[1] ? 4'b1100 : 4'b0011;
                    new_wdata = {2{WriteData[15:0]}};
                end
                default: new_wdata = WriteData;
            endcase
        end
    end

    always_comb begin
        byte_sel = bus_rdata[{adr_lo, 3'b000} +: 8];
        half_sel = adr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3[1:0])
            2'b00:   load_val = {{24{~f3[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~f3[2] & half_sel[15]}}, half_sel};
            default: load_val = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 8'd0;
            adr_lo    <= 2'b00;
            f3        <= 3'b000;
            we        <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_be    <= 4'b0000;
            ReadData  <= 32'h0;
            Err       <= 1'b0;
        end else begin
            if (start && !trap) begin
                adr_lo    <= DataAdr[1:0];
                f3        <= Funct3;
                we        <= MemWrite;
                bus_we    <= MemWrite;
                bus_addr  <= {DataAdr[31:2], 2'b00};
                bus_wdata <= new_wdata;
                bus_be    <= new_be;
            end
            if (start)
                cnt <= 8'd0;
            else if (state == REQ && !bus_ack)
                cnt <= cnt + 8'd1;
            Err <= timeout_hit | trap;
            if (state == REQ && bus_ack && !we)
                ReadData <= load_val;
            else if (timeout_hit || trap)
                ReadData <= 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Testbench for load_store_unit: directed vector table, reset/ack corner
// sequences, and randomized accesses against a behavioural model.
module tb_load_store_unit;

    localparam int TO = 4;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] DataAdr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, Err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_rd = 32'h0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .Err(Err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_ld(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        if (f == 3'd0 || f == 3'd4) begin
            v = (r >> (8 * (a % 4))) % 256;
            if (f == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (f == 3'd1 || f == 3'd5) begin
            v = (r >> (16 * ((a % 4) / 2))) % 65536;
            if (f == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f, input logic [31:0] a);
        if (!wr)       return 4'hF;
        if (f == 3'd0) return 4'(1 << (a % 4));
        if (f == 3'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f, input logic [31:0] d);
        if (f == 3'd0) return (d % 256) * 32'h01010101;
        if (f == 3'd1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic bit m_mis(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'd1 || f == 3'd5) return (a % 2) != 0;
        if (f == 3'd0 || f == 3'd4) return 1'b0;
        return (a % 4) != 0;
    endfunction

    // One complete access; delay = REQ cycles without ack before ack arrives
    task automatic access(input bit wr, input bit rdq, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdata, input int delay,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] rd, input string tag);
        bit trap, to;
        int n;
        trap = TRAP && m_mis(f, a);
        to   = !trap && delay >= TO;
        MemWrite = wr; MemRead = rdq; Funct3 = f; DataAdr = a; WriteData = d;
        bus_ack = 1'b0;
        #1;
        chk({tag, " stall_idle"}, 32'(Stall), 32'd1);
        @(posedge clk); #1;
        if (trap) begin
            chk({tag, " trap_no_req"}, 32'(bus_req), 32'd0);
        end else begin
            chk({tag, " req"}, 32'(bus_req), 32'd1);
            chk({tag, " stall_req"}, 32'(Stall), 32'd1);
            chk({tag, " addr"}, bus_addr, a - (a % 4));
            chk({tag, " be"}, 32'(bus_be), 32'(be));
            chk({tag, " we"}, 32'(bus_we), 32'(wr));
            if (wr) chk({tag, " wdata"}, bus_wdata, wd);
            n = 0;
            while (bus_req && n < 300) begin
                bus_ack   = (n == delay);
                bus_rdata = (n == delay) ? rdata : $urandom;
                @(posedge clk); #1;
                n++;
            end
            bus_ack = 1'b0;
            chk({tag, " req_cycles"}, 32'(n), to ? 32'(TO) : 32'(delay + 1));
        end
        chk({tag, " err"}, 32'(Err), 32'(trap || to));
        chk({tag, " stall_done"}, 32'(Stall), 32'd0);
        chk({tag, " rdata"}, ReadData, rd);
        model_rd = rd;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        chk({tag, " err_clear"}, 32'(Err), 32'd0);
    endtask

    typedef struct {
        bit          wr;
        bit          rdq;
        logic [2:0]  f;
        logic [31:0] a, d, rdata;
        int          delay;
        logic [3:0]  be;
        logic [31:0] wd, rd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{0, 1, 3'd0, 32'h203, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{0, 1, 3'd4, 32'h203, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0, 32'h00000080};
        tbl[3]  = '{1, 0, 3'd1, 32'h002, 32'h0000ABCD, 32'h0,        0, 4'hC, 32'hABCDABCD, 32'h00000080};
        tbl[4]  = '{0, 1, 3'd1, 32'h002, 32'h0,        32'h80FF1234, 1, 4'hF, 32'h0, 32'hFFFF80FF};
        tbl[5]  = '{0, 1, 3'd5, 32'h000, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0, 32'h00001234};
        tbl[6]  = '{1, 0, 3'd0, 32'h001, 32'h123456A5, 32'h0,        2, 4'h2, 32'hA5A5A5A5, 32'h00001234};
        tbl[7]  = '{0, 1, 3'd2, 32'h101, 32'h0,        32'h0CAFE001, 0, 4'hF, 32'h0, TRAP ? 32'h0 : 32'h0CAFE001};
        tbl[8]  = '{0, 1, 3'd1, 32'h003, 32'h0,        32'h7FFF0000, 0, 4'hF, 32'h0, TRAP ? 32'h0 : 32'h00007FFF};
        tbl[9]  = '{0, 1, 3'd0, 32'h000, 32'h0,        32'h0000007F, 3, 4'hF, 32'h0, 32'h0000007F};
        tbl[10] = '{0, 1, 3'd6, 32'h000, 32'h0,        32'h89ABCDEF, 0, 4'hF, 32'h0, 32'h89ABCDEF};
        tbl[11] = '{0, 1, 3'd2, 32'h008, 32'h0,        32'h11111111, 9, 4'hF, 32'h0, 32'h0};
        tbl[12] = '{0, 1, 3'd5, 32'h002, 32'h0,        32'hFEDC0000, 0, 4'hF, 32'h0, 32'h0000FEDC};
        tbl[13] = '{1, 1, 3'd2, 32'h010, 32'h11223344, 32'h0,        0, 4'hF, 32'h11223344, 32'h0000FEDC};

        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
        DataAdr = 32'h0; WriteData = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst ReadData", ReadData, 32'h0);
        chk("rst Stall", 32'(Stall), 32'd0);
        chk("rst Err", 32'(Err), 32'd0);
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        chk("rst bus_be", 32'(bus_be), 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++)
            access(tbl[i].wr, tbl[i].rdq, tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].rdata,
                   tbl[i].delay, tbl[i].be, tbl[i].wd, tbl[i].rd, $sformatf("vec%0d", i));

        // Ack with no access in flight must change nothing
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("stray_ack rdata", ReadData, model_rd);
        chk("stray_ack req", 32'(bus_req), 32'd0);
        chk("stray_ack stall", 32'(Stall), 32'd0);
        bus_ack = 1'b0;

        // Reset in the middle of a bus request
        MemRead = 1'b1; Funct3 = 3'd2; DataAdr = 32'h40;
        @(posedge clk); #1;
        chk("midrst req_before", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst req", 32'(bus_req), 32'd0);
        chk("midrst stall", 32'(Stall), 32'd0);
        chk("midrst err", 32'(Err), 32'd0);
        MemRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst idle_req", 32'(bus_req), 32'd0);
        chk("midrst idle_stall", 32'(Stall), 32'd0);
        chk("midrst idle_err", 32'(Err), 32'd0);
        chk("midrst rdata", ReadData, 32'h0);
        model_rd = 32'h0;

        for (int i = 0; i < 60; i++) begin
            bit          wr, trap, to;
            logic [2:0]  f;
            logic [31:0] a, d, r, exp_rd;
            int          dl;
            wr = 1'($urandom % 2);
            f  = wr ? 3'($urandom % 3) : 3'($urandom % 8);
            a  = $urandom; d = $urandom; r = $urandom;
            dl = int'($urandom % 6);
            trap = TRAP && m_mis(f, a);
            to   = !trap && dl >= TO;
            if (trap || to) exp_rd = 32'h0;
            else if (wr)    exp_rd = model_rd;
            else            exp_rd = m_ld(f, a, r);
            access(wr, !wr, f, a, d, r, dl, m_be(wr, f, a), m_wd(f, d), exp_rd,
                   $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum cycles bus_req may wait for bus_ack (legal 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 MemRead  input  1  core load request; level, held until Stall low.
REQ-005 MemWrite  input  1  core store request; level, held until Stall low.
REQ-006 Funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 DataAdr  input  32  byte address from ALU.
REQ-008 WriteData  input  32  store data (rs2 value).
REQ-009 ReadData  output  32  aligned, sign/zero-extended load result.
REQ-010 Stall  output  1  freezes PC and register writeback while high.
REQ-011 Err  output  1  one-cycle pulse on timeout or (if enabled) misalignment.
REQ-012 bus_req / bus_we  output  1 / 1  bus request and write qualifier.
REQ-013 bus_addr  output  32  word-aligned address (bits [1:0] = 00).
REQ-014 bus_wdata / bus_be  output  32 / 4  lane-replicated store data and byte enables.
REQ-015 bus_rdata / bus_ack  input  32 / 1  read data and completion, sampled together.

Function
REQ-016 FSM states: IDLE, REQ, DONE.
REQ-017 In IDLE, MemRead or MemWrite asserted: latch address, Funct3, store data, and direction; go to REQ. MemWrite wins if both are asserted.
REQ-018 Stall is combinational: high in IDLE while a request is present, high in REQ, low in DONE. Zero-wait access costs 3 cycles: IDLE, REQ, DONE.
REQ-019 In REQ, bus_req is high and bus_addr, bus_we, bus_be, bus_wdata are held stable. When bus_ack is high, go to DONE and register the load result.
REQ-020 DONE lasts exactly one cycle, then returns to IDLE. A request present in that IDLE starts a new access.
REQ-021 bus_be and bus_wdata by access type:
  - SB: bus_be = 0001 << addr[1:0]; byte replicated 4x.
  - SH: bus_be = 0011 (addr[1]=0) or 1100 (addr[1]=1); half replicated 2x.
  - SW: bus_be = 1111.
  - Loads: bus_be = 1111.
REQ-022 Load extraction: select the byte or half using latched addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend. Funct3 011/110/111 on a load is treated as LW.
REQ-023 ReadData holds its last value until the next completed load; a store leaves it unchanged.
REQ-024 Timeout counter: cleared on entry to REQ, increments each REQ cycle without ack. On reaching TIMEOUT: drop bus_req, go to DONE, pulse Err, set ReadData to 0.
REQ-025 bus_ack outside REQ is ignored.
REQ-026 bus_ack arriving on the timeout cycle counts as success; no Err.

Reset
REQ-027 rst forces IDLE; counter = 0; ReadData = 0; Err, bus_req, bus_we = 0; bus_addr, bus_wdata = 0; bus_be = 0000.
REQ-028 rst asserted mid-transaction drops bus_req immediately (asynchronous) and discards the access. No Err is generated.

Configuration
REQ-029 Macro MISALIGN_TRAP_EN, when defined, makes misaligned accesses trap instead of issuing a bus request:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=00.
  - FSM goes IDLE->DONE; Err pulses in DONE; ReadData = 0; a store has no effect.
REQ-030 Without MISALIGN_TRAP_EN:
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - The access proceeds normally; Err comes only from timeout.

Verification
REQ-031 SW addr 0x104, data 0xDEADBEEF, ack in first REQ cycle -> bus_addr 0x104, bus_be 1111, bus_wdata 0xDEADBEEF; Stall high 2 cycles, low in the 3rd.
REQ-032 LB addr 0x203, bus_rdata 0x80FF1234 -> ReadData 0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-033 SH addr 0x002, data 0x0000ABCD -> bus_be 1100, bus_wdata 0xABCDABCD, bus_addr 0x000.
REQ-034 TIMEOUT=4, LW with bus_ack never asserted -> bus_req high 4 cycles then low; Err high 1 cycle; ReadData 0; Stall low in DONE.
REQ-035 LW addr 0x101 -> with MISALIGN_TRAP_EN: no bus_req, Err pulse; without: bus_addr 0x100, bus_be 1111.
REQ-036 rst pulsed while bus_req high -> bus_req, Stall, Err low in the same cycle; state IDLE after release.
